// File: rtl/pixel_queue_writer_pkg.sv
// Shared constants for the input-layer pixel queue writer.
// Holds the frame geometry, pixel width, binarisation threshold, FIFO depth
// and the controller state encoding. The interface, FIFO and top import it.
package pixel_queue_writer_pkg;

  localparam int IMAGE_PIXELS     = 784;   // 28x28 frame
  localparam int PIXEL_ADDR_WIDTH = 10;    // 2^10 >= 784
  localparam int PIXEL_BIT_WIDTH  = 8;     // grayscale sample width
  localparam int PIXEL_THRESHOLD  = 128;   // set iff pixel >= threshold
  localparam int ADDR_FIFO_DEPTH  = 1024;  // >= IMAGE_PIXELS, so it never fills

  typedef enum logic [1:0] {
    LOAD  = 2'd0,  // accepting pixels of a frame
    READY = 2'd1,  // frame enqueued, Layer 1 draining the queue
    EMPTY = 2'd2   // frame had no set pixels, one-cycle notification
  } pqw_state_e;

endpackage

// File: rtl/pixel_queue_writer_if.sv
// Bus between the pixel source / Layer 1 controller and pixel_queue_writer.
// Signals:
//   pixelValid, pixelIn, pixelReady : serial raster pixel stream
//   dequeue, queueOut, queueEmpty   : FWFT active-pixel queue toward Layer 1
//   inputsReady                     : whole frame enqueued, queue may drain
//   setCount                        : addresses enqueued for current/last frame
//   emptyFrame                      : pulse when a frame had no set pixels
// Modports: slave = pixel_queue_writer, master = source / consumer side.
interface pixel_queue_writer_if;
  import pixel_queue_writer_pkg::*;

  logic                        pixelValid;
  logic [PIXEL_BIT_WIDTH-1:0]  pixelIn;
  logic                        pixelReady;
  logic                        dequeue;
  logic [PIXEL_ADDR_WIDTH-1:0] queueOut;
  logic                        queueEmpty;
  logic                        inputsReady;
  logic [PIXEL_ADDR_WIDTH-1:0] setCount;
  logic                        emptyFrame;

  modport master (
    output pixelValid, pixelIn, dequeue,
    input  pixelReady, queueOut, queueEmpty, inputsReady, setCount, emptyFrame
  );

  modport slave (
    input  pixelValid, pixelIn, dequeue,
    output pixelReady, queueOut, queueEmpty, inputsReady, setCount, emptyFrame
  );

endinterface

// File: rtl/pixel_queue_writer_addr_fifo.sv
// Synchronous first-word-fall-through FIFO for pixel addresses.
// Ports:
//   clk, reset : clock, synchronous active-low reset (clears pointers only)
//   push, dataIn : write one entry (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   dataOut      : head entry, forced to 0 while empty
//   empty        : registered, tracks count == 0
//   count        : number of stored entries
module pixel_queue_writer_addr_fifo #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         dataIn,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count_next;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == (AW+1)'(DEPTH));
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      empty <= (count_next == '0);
    end
  end

  // Storage carries no reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= dataIn;
  end

  assign dataOut = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pixel_queue_writer.sv
// Input-layer front end: thresholds a serial 28x28 grayscale frame and
// enqueues the raster address of every set pixel for the Layer 1 controller.
// Ports:
//   clk   : clock
//   reset : synchronous active-low reset; discards any partial frame
//   bus   : pixel_queue_writer_if.slave (pixel stream in, address queue out)
module pixel_queue_writer
  import pixel_queue_writer_pkg::*;
#(
  parameter int PIXELS     = IMAGE_PIXELS,
  parameter int ADDR_W     = PIXEL_ADDR_WIDTH,  // must match the interface
  parameter int PIX_W      = PIXEL_BIT_WIDTH,   // must match the interface
  parameter int THRESHOLD  = PIXEL_THRESHOLD,
  parameter int FIFO_DEPTH = ADDR_FIFO_DEPTH
) (
  input logic                 clk,
  input logic                 reset,
  pixel_queue_writer_if.slave bus
);

  pqw_state_e                  state_q;
  pqw_state_e                  state_d;
  logic [ADDR_W-1:0]           idx;
  logic [ADDR_W-1:0]           set_count;
  logic [ADDR_W-1:0]           count_next;
  logic                        accept;
  logic                        hit;
  logic                        last_pixel;
  logic                        pop;
  logic                        fifo_empty;
  logic [ADDR_W-1:0]           fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  function automatic logic is_set(input logic [PIX_W-1:0] p);
    return int'({1'b0, p}) >= THRESHOLD;
  endfunction

  assign accept     = (state_q == LOAD) && bus.pixelValid;
  assign hit        = accept && is_set(bus.pixelIn);
  assign last_pixel = (idx == ADDR_W'(PIXELS - 1));
  // First pixel of a frame restarts the tally, so it survives the drain.
  assign count_next = ((idx == '0) ? '0 : set_count) + ADDR_W'(hit);
  assign pop        = (state_q == READY) && bus.dequeue && (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= LOAD;
      idx       <= '0;
      set_count <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        set_count <= count_next;
        idx       <= last_pixel ? '0 : idx + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (accept && last_pixel) state_d = (count_next != '0) ? READY : EMPTY;
      // Leave only after a full cycle with queueEmpty visible to Layer 1.
      READY:   if (fifo_empty) state_d = LOAD;
      EMPTY:   state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    bus.pixelReady  = 1'b0;
    bus.inputsReady = 1'b0;
    bus.emptyFrame  = 1'b0;
    case (state_q)
      LOAD:    bus.pixelReady = 1'b1;
      READY:   bus.inputsReady = 1'b1;
      EMPTY: begin
        bus.inputsReady = 1'b1;
        bus.emptyFrame  = 1'b1;
      end
      default: bus.pixelReady = 1'b0;
    endcase
  end

  assign bus.queueOut   = fifo_head;
  assign bus.queueEmpty = fifo_empty;
  assign bus.setCount   = set_count;

  pixel_queue_writer_addr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (hit),
    .pop     (pop),
    .dataIn  (idx),
    .dataOut (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: doc/pixel_queue_writer.md
Name: pixel_queue_writer

Overview:
Input-layer front end that feeds the Layer 1 controller's active-pixel queue. It accepts one 28x28 grayscale image as a serial pixel stream and thresholds each pixel to binary. The 10-bit address of every set pixel is written into an internal FIFO. The FIFO is then presented as the queueOut / queueEmpty / dequeue / inputsReady interface that Layer 1 consumes.

Parameters:
PIXELS, 784, pixels per frame; addresses 0..PIXELS-1.
ADDR_W, 10, pixel address width; must satisfy 2^ADDR_W >= PIXELS.
PIX_W, 8, grayscale input pixel width.
THRESHOLD, 128, a pixel is set iff pixelIn >= THRESHOLD (unsigned).
FIFO_DEPTH, 1024, address FIFO depth; must be >= PIXELS, so overflow is impossible by construction.

Ports:
clk  in  1  single clock; all state changes on posedge.
reset  in  1  synchronous, active-low reset (reset==0 at posedge clears all state).
pixelValid  in  1  upstream pixel present.
pixelIn  in  PIX_W  grayscale pixel value, raster order.
pixelReady  out  1  block accepts a pixel this cycle.
dequeue  in  1  Layer 1 pops the head entry, sampled at posedge.
queueOut  out  ADDR_W  head of FIFO (first-word fall-through); 0 when empty.
queueEmpty  out  1  FIFO holds no entries.
inputsReady  out  1  full frame enqueued, queue may be drained.
setCount  out  ADDR_W  number of addresses enqueued for the current/last frame.
emptyFrame  out  1  one-cycle pulse: frame completed with zero set pixels.

Behaviour:
- Reset values: pixelReady=1, queueOut=0, queueEmpty=1, inputsReady=0, setCount=0, emptyFrame=0.
- Reset also sets pixel index=0, FIFO pointers=0, state=LOAD. Reset has priority over every other event and may occur in any state, including mid-frame. A partial frame is discarded.
- State LOAD:
  - pixelReady=1, inputsReady=0. dequeue is ignored.
  - Accept condition: posedge with pixelValid=1.
  - On accept, if pixelIn >= THRESHOLD: push the current index into the FIFO and increment setCount.
  - The index increments on every accept.
  - On the accept of index PIXELS-1: index wraps to 0. If setCount (including this push) > 0, go to READY; otherwise go to EMPTY.
  - setCount is cleared on the first accept (index 0) of a new frame, not on leaving READY, so it stays readable after drain.
- State READY:
  - pixelReady=0, inputsReady=1.
  - dequeue=1 at posedge with the FIFO non-empty: pop, and queueOut shows the next entry after that edge.
  - dequeue while the FIFO is empty is ignored; pointers do not move and no underflow occurs.
  - On a posedge with the FIFO empty (queueEmpty=1 during that cycle): go to LOAD. inputsReady therefore stays high for exactly one cycle with queueEmpty=1, so Layer 1 sees its end-of-queue condition.
- State EMPTY:
  - Lasts exactly one cycle: inputsReady=1, queueEmpty=1, emptyFrame=1, pixelReady=0.
  - Then go to LOAD.
- Latency:
  - The last pixel accepted at edge N gives inputsReady=1 and a valid queueOut from edge N onward.
  - Pop-to-next-head latency is 1 edge.
- Push and pop never occur in the same cycle (state-exclusive). The FIFO still uses ADDR_W+1 bit pointers for full/empty, and the full flag is never asserted.
- queueEmpty is registered from the FIFO count, not derived combinationally from dequeue.
- Addresses are emitted in strictly increasing raster order within a frame.

Decomposition:
- Shared constants file: IMAGE_PIXELS (784), PIXEL_ADDR_WIDTH (10), PIXEL_BIT_WIDTH (8), PIXEL_THRESHOLD, state encodings LOAD/READY/EMPTY.
- One natural sub-module: addr_fifo, a synchronous FWFT FIFO with parameters DEPTH and WIDTH, ports push/pop/dataIn/dataOut/empty/count.
- Thresholding, index counter and FSM stay in pixel_queue_writer.

Test Plan:
1. Hold reset=0 for 3 cycles, then release -> pixelReady=1, queueEmpty=1, inputsReady=0, queueOut=0, setCount=0.
2. Frame with pixels 0, 5, 783 = 200 and all others 0, then drain -> after the last accept: inputsReady=1, queueOut=0, setCount=3. Three dequeues give 5, then 783, then queueEmpty=1. One cycle later inputsReady=0 and pixelReady=1.
3. Threshold boundary: pixel 10 = 127, pixel 11 = 128, all others 0 -> only address 11 enqueued, setCount=1.
4. All-zero frame -> emptyFrame pulses for 1 cycle with inputsReady=1 and queueEmpty=1, then LOAD. The next frame's indices start at 0.
5. All-255 frame with back-to-back dequeue -> queueOut sequence 0..783 with no gaps or duplicates, setCount=784. dequeue asserted during LOAD or after empty has no effect.
6. Reset=0 after 400 pixels of a frame -> FIFO empty, index 0. A following full frame with only pixel 0 set yields setCount=1 and queueOut=0.
